// File: rtl/test_data_loader.sv
// test_data_loader
// Collects one test sample (N feature bytes followed by one label byte) from a
// valid/ready byte stream, launches the network datapath with a one-cycle start
// pulse, waits for a rising edge of the datapath's result-ready level, captures
// the class index, reports it with a one-cycle class_valid pulse and keeps
// running counts of evaluated and correctly classified samples.
//
// Ports
//   clk, rst     : single clock, asynchronous active-high reset
//   in_valid     : upstream byte valid
//   in_data      : upstream byte (feature or label)
//   in_ready     : loader accepts a byte this cycle (LOAD state only)
//   clr_stats    : synchronous clear of sample_cnt / correct_cnt
//   test_data    : packed feature vector, byte k at [DW*k +: DW]
//   start        : one-cycle launch pulse to the datapath
//   nn_ready     : datapath result-ready level
//   test_out     : class index from the datapath
//   class_valid  : one-cycle pulse marking a freshly captured result
//   class_out    : captured class index
//   label_out    : label of the captured sample
//   correct      : class_out equals the zero-extended label
//   sample_cnt   : samples evaluated (saturating)
//   correct_cnt  : samples classified correctly (saturating)
module test_data_loader #(
    parameter int DW = 8,
    parameter int N  = 62
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic            clr_stats,
    output logic [N*DW-1:0] test_data,
    output logic            start,
    input  logic            nn_ready,
    input  logic [7:0]      test_out,
    output logic            class_valid,
    output logic [7:0]      class_out,
    output logic [DW-1:0]   label_out,
    output logic            correct,
    output logic [15:0]     sample_cnt,
    output logic [15:0]     correct_cnt
);

    typedef enum logic [1:0] {LOAD, START, RUN, REPORT} state_t;

    state_t        state;
    state_t        next_state;
    logic [6:0]    byte_cnt;
    logic [DW-1:0] label;
    logic          nn_prev;
    logic          accept;
    logic          label_byte;
    logic          capture;
    logic          start_next;
    logic          class_valid_next;

    // A byte is consumed only on a valid/ready handshake; the byte arriving
    // when the counter already equals N is the label. A result is captured
    // only on a 0->1 transition of nn_ready seen while in RUN, so a level that
    // was already high on entry to RUN is ignored until it falls and rises.
    always_comb begin
        accept     = in_valid && in_ready;
        label_byte = accept && (byte_cnt == 7'(N));
        capture    = (state == RUN) && nn_ready && !nn_prev;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (label_byte) next_state = START;
            START:   next_state = RUN;
            RUN:     if (capture) next_state = REPORT;
            REPORT:  next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Output decode. start and class_valid are registered from the decoded
    // next state so they coincide exactly with the START and REPORT cycles.
    always_comb begin
        in_ready         = (state == LOAD);
        start_next       = (next_state == START);
        class_valid_next = (next_state == REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start       <= 1'b0;
            class_valid <= 1'b0;
        end else begin
            start       <= start_next;
            class_valid <= class_valid_next;
        end
    end

    // Feature/label capture. Only the byte lane addressed by the counter is
    // written, so test_data stays frozen outside LOAD handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= 7'd0;
            label     <= '0;
            test_data <= '0;
        end else if (accept) begin
            if (label_byte) begin
                label    <= in_data;
                byte_cnt <= 7'd0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (byte_cnt == 7'(k)) begin
                        test_data[DW*k +: DW] <= in_data;
                    end
                end
                byte_cnt <= byte_cnt + 7'd1;
            end
        end
    end

    // Result capture; nn_prev holds last cycle's nn_ready for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nn_prev   <= 1'b0;
            class_out <= 8'd0;
            label_out <= '0;
            correct   <= 1'b0;
        end else begin
            nn_prev <= nn_ready;
            if (capture) begin
                class_out <= test_out;
                label_out <= label;
                correct   <= ({{DW{1'b0}}, test_out} == {8'd0, label});
            end
        end
    end

    // Saturating statistics; a clear request overrides the REPORT update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt  <= 16'd0;
            correct_cnt <= 16'd0;
        end else if (clr_stats) begin
            sample_cnt  <= 16'd0;
            correct_cnt <= 16'd0;
        end else if (state == REPORT) begin
            if (sample_cnt != 16'hFFFF) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (correct && (correct_cnt != 16'hFFFF)) begin
                correct_cnt <= correct_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_test_data_loader.sv
// tb_test_data_loader
// Directed self-checking bench for test_data_loader: full samples with correct
// and wrong classifications, a pre-held nn_ready level, gappy input with
// in_valid driven outside LOAD, a mid-sample reset, and counter saturation
// followed by a clear coinciding with REPORT.
module tb_test_data_loader;

    localparam int DW = 8;
    localparam int N  = 62;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            clr_stats;
    logic [N*DW-1:0] test_data;
    logic            start;
    logic            nn_ready;
    logic [7:0]      test_out;
    logic            class_valid;
    logic [7:0]      class_out;
    logic [DW-1:0]   label_out;
    logic            correct;
    logic [15:0]     sample_cnt;
    logic [15:0]     correct_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [N*DW-1:0] exp_data;

    test_data_loader #(.DW(DW), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .clr_stats   (clr_stats),
        .test_data   (test_data),
        .start       (start),
        .nn_ready    (nn_ready),
        .test_out    (test_out),
        .class_valid (class_valid),
        .class_out   (class_out),
        .label_out   (label_out),
        .correct     (correct),
        .sample_cnt  (sample_cnt),
        .correct_cnt (correct_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the flow ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it is accepted. Optional random idle
    // cycles with in_valid low precede the byte. in_valid is left high.
    task automatic applyStimulus(input logic [7:0] data, input bit gappy);
        int waited;
        if (gappy) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = data;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checkOutput("ready_wait", {511'd0, in_ready}, 512'd1);
        end
        tick();
    endtask

    // Load N features (base, base+1, ...) and the label. Returns just after
    // the label-acceptance edge, i.e. in the START cycle.
    task automatic loadSample(input logic [7:0] base, input logic [7:0] label,
                              input bit gappy);
        for (int k = 0; k < N; k++) begin
            exp_data[DW*k +: DW] = base + 8'(k);
            applyStimulus(base + 8'(k), gappy);
        end
        checkOutput("start_before_label", {511'd0, start}, 512'd0);
        checkOutput("ready_before_label", {511'd0, in_ready}, 512'd1);
        applyStimulus(label, gappy);
        checkOutput("start_latency", {511'd0, start}, 512'd1);
        checkOutput("ready_after_label", {511'd0, in_ready}, 512'd0);
        checkOutput("test_data", {16'd0, test_data}, {16'd0, exp_data});
    endtask

    // From RUN: drop nn_ready for a cycle, raise it with the class index and
    // check the report pulse and the counters that follow it.
    task automatic captureResult(input logic [7:0] cls, input logic [7:0] label,
                                 input logic exp_correct, input logic [15:0] exp_samples,
                                 input logic [15:0] exp_corrects, input bit clr_in_report);
        nn_ready = 1'b0;
        tick();
        checkOutput("no_early_valid", {511'd0, class_valid}, 512'd0);
        nn_ready = 1'b1;
        test_out = cls;
        tick();
        checkOutput("class_valid", {511'd0, class_valid}, 512'd1);
        checkOutput("start_with_valid", {511'd0, start}, 512'd0);
        checkOutput("class_out", {504'd0, class_out}, {504'd0, cls});
        checkOutput("label_out", {504'd0, label_out}, {504'd0, label});
        checkOutput("correct", {511'd0, correct}, {511'd0, exp_correct});
        checkOutput("test_data_run", {16'd0, test_data}, {16'd0, exp_data});
        nn_ready  = 1'b0;
        test_out  = 8'hFF;
        clr_stats = clr_in_report;
        tick();
        clr_stats = 1'b0;
        checkOutput("valid_one_cycle", {511'd0, class_valid}, 512'd0);
        checkOutput("ready_back", {511'd0, in_ready}, 512'd1);
        checkOutput("class_out_hold", {504'd0, class_out}, {504'd0, cls});
        checkOutput("sample_cnt", {496'd0, sample_cnt}, {496'd0, exp_samples});
        checkOutput("correct_cnt", {496'd0, correct_cnt}, {496'd0, exp_corrects});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        clr_stats = 1'b0;
        nn_ready  = 1'b0;
        test_out  = 8'd0;
        exp_data  = '0;
        #12;
        checkOutput("rst_test_data", {16'd0, test_data}, 512'd0);
        checkOutput("rst_start", {511'd0, start}, 512'd0);
        checkOutput("rst_class_valid", {511'd0, class_valid}, 512'd0);
        checkOutput("rst_class_out", {504'd0, class_out}, 512'd0);
        checkOutput("rst_sample_cnt", {496'd0, sample_cnt}, 512'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", {511'd0, in_ready}, 512'd1);

        // Bytes 1..62, label 3, class 3: correct.
        loadSample(8'd1, 8'd3, 1'b0);
        in_valid = 1'b0;
        tick();
        checkOutput("start_width", {511'd0, start}, 512'd0);
        captureResult(8'd3, 8'd3, 1'b1, 16'd1, 16'd1, 1'b0);

        // Same sample, class 5: wrong.
        loadSample(8'd1, 8'd3, 1'b0);
        in_valid = 1'b0;
        tick();
        captureResult(8'd5, 8'd3, 1'b0, 16'd2, 16'd1, 1'b0);

        // nn_ready already high before START: must wait for a fresh rise.
        nn_ready = 1'b1;
        test_out = 8'd7;
        loadSample(8'h10, 8'd7, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("held_nn_ignored", {511'd0, class_valid}, 512'd0);
        end
        captureResult(8'd7, 8'd7, 1'b1, 16'd3, 16'd2, 1'b0);

        // Gappy input; in_valid held high with junk data during RUN.
        loadSample(8'h80, 8'd2, 1'b1);
        in_data = 8'hEE;
        tick();
        tick();
        checkOutput("ready_in_run", {511'd0, in_ready}, 512'd0);
        checkOutput("data_in_run", {16'd0, test_data}, {16'd0, exp_data});
        captureResult(8'd9, 8'd2, 1'b0, 16'd4, 16'd2, 1'b0);
        loadSample(8'hC0, 8'd9, 1'b1);
        in_valid = 1'b0;
        tick();
        captureResult(8'd9, 8'd9, 1'b1, 16'd5, 16'd3, 1'b0);

        // Reset after 30 bytes of a sample, then a complete fresh sample.
        for (int k = 0; k < 30; k++) begin
            applyStimulus(8'h40 + 8'(k), 1'b0);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_test_data", {16'd0, test_data}, 512'd0);
        checkOutput("midrst_sample_cnt", {496'd0, sample_cnt}, 512'd0);
        checkOutput("midrst_label_out", {504'd0, label_out}, 512'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", {511'd0, in_ready}, 512'd1);
        loadSample(8'h21, 8'd4, 1'b0);
        in_valid = 1'b0;
        tick();
        captureResult(8'd4, 8'd4, 1'b1, 16'd1, 16'd1, 1'b0);

        // Saturation from a forced preload, then a clear during REPORT.
        force dut.sample_cnt = 16'hFFFE;
        force dut.correct_cnt = 16'hFFFE;
        #1;
        release dut.sample_cnt;
        release dut.correct_cnt;
        loadSample(8'h05, 8'd1, 1'b0);
        in_valid = 1'b0;
        tick();
        captureResult(8'd1, 8'd1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        loadSample(8'h06, 8'd1, 1'b0);
        in_valid = 1'b0;
        tick();
        captureResult(8'd1, 8'd1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        loadSample(8'h07, 8'd1, 1'b0);
        in_valid = 1'b0;
        tick();
        captureResult(8'd1, 8'd1, 1'b1, 16'd0, 16'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
